// File: rtl/kernel_bc_fifo_pkg.sv
// Shared definitions for the kernel_bc shift-register FIFO: count width helper,
// status-flag reset values and the parameter legality predicate.
// Optional feature macro used by the top: KERNEL_BC_FIFO_ERRFLAG_EN.
package kernel_bc_fifo_pkg;

    // Status flag values while reset_n is low (empty FIFO).
    localparam logic EMPTY_N_RST = 1'b0;
    localparam logic FULL_N_RST  = 1'b1;
    localparam logic AFULL_RST   = 1'b0;
    localparam logic AEMPTY_RST  = 1'b1;

    // Bits needed to hold an occupancy of 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // True when the parameter set describes a buildable FIFO.
    function automatic bit params_ok(input int data_width, input int addr_width,
                                     input int depth, input int afull_thresh,
                                     input int aempty_thresh);
        return (data_width >= 1) && (depth >= 2) && (depth <= (1 << addr_width)) &&
               (cnt_width(depth) <= addr_width + 1) &&
               (afull_thresh >= 1) && (afull_thresh <= depth) &&
               (aempty_thresh >= 0) && (aempty_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/kernel_bc_fifo_srl_cnt_shiftReg.sv
// Shift-register storage for the kernel_bc FIFO. New data enters entry[0];
// the read port is a plain mux over all entries. Storage is never reset.
module kernel_bc_fifo_srl_cnt_shiftReg #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Shift every entry up by one on an accepted write.
    always_ff @(posedge clk) begin
        if (ce) begin
            mem_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    // Read mux; out-of-range addresses fall back to entry[0].
    always_comb begin
        dout = mem_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (addr == ADDR_WIDTH'(i)) begin
                dout = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/kernel_bc_fifo_srl_cnt.sv
// First-word fall-through shift-register FIFO with registered occupancy count
// and almost-full / almost-empty look-ahead flags.
// Optional: define KERNEL_BC_FIFO_ERRFLAG_EN to add sticky if_overflow and
// if_underflow outputs (cleared only by reset_n).
module kernel_bc_fifo_srl_cnt
    import kernel_bc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 4,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic [ADDR_WIDTH:0]   if_count,
    output logic                  if_almost_full,
    output logic                  if_almost_empty
`ifdef KERNEL_BC_FIFO_ERRFLAG_EN
    ,
    output logic                  if_overflow,
    output logic                  if_underflow
`endif
);

    localparam int CW = ADDR_WIDTH + 1;

    if (!params_ok(DATA_WIDTH, ADDR_WIDTH, DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
        $error("kernel_bc_fifo_srl_cnt: illegal DEPTH/ADDR_WIDTH/threshold combination");
    end

    logic                  wr_en;
    logic                  rd_en;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Accept/reject decisions, next count and flags derived from that next count.
    always_comb begin
        wr_en   = if_write & if_write_ce & full_n_q;
        rd_en   = if_read & if_read_ce & empty_n_q;
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CW'(1);
        end
        empty_n_d = (count_d != '0);
        full_n_d  = (count_d != CW'(DEPTH));
        afull_d   = (count_d >= CW'(AFULL_THRESH));
        aempty_d  = (count_d <= CW'(AEMPTY_THRESH));
        // Oldest entry sits at count-1; at count==2**ADDR_WIDTH the truncation still lands on DEPTH-1.
        rd_addr   = (count_q == '0) ? '0 : ADDR_WIDTH'(count_q - CW'(1));
    end

    // Occupancy and status flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            empty_n_q <= EMPTY_N_RST;
            full_n_q  <= FULL_N_RST;
            afull_q   <= AFULL_RST;
            aempty_q  <= AEMPTY_RST;
        end else begin
            count_q   <= count_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
        end
    end

    kernel_bc_fifo_srl_cnt_shiftReg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_shift_reg (
        .clk  (clk),
        .ce   (wr_en),
        .din  (if_din),
        .addr (rd_addr),
        .dout (if_dout)
    );

    assign if_count        = count_q;
    assign if_empty_n      = empty_n_q;
    assign if_full_n       = full_n_q;
    assign if_almost_full  = afull_q;
    assign if_almost_empty = aempty_q;

`ifdef KERNEL_BC_FIFO_ERRFLAG_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky misuse flags: any enabled request against a full/empty FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (if_write && if_write_ce && !full_n_q) begin
                overflow_q <= 1'b1;
            end
            if (if_read && if_read_ce && !empty_n_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign if_overflow  = overflow_q;
    assign if_underflow = underflow_q;
`else
    // Error flags not built: rejected requests are silently dropped.
`endif

endmodule

// File: tb/tb_kernel_bc_fifo_srl_cnt.sv
// Directed bench for kernel_bc_fifo_srl_cnt with DATA_WIDTH=8, DEPTH=4,
// AFULL_THRESH=3, AEMPTY_THRESH=1. Checks the error flags when
// KERNEL_BC_FIFO_ERRFLAG_EN is defined.
module tb_kernel_bc_fifo_srl_cnt;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       if_empty_n, if_full_n, if_almost_full, if_almost_empty;
    logic       if_read_ce = 1'b0, if_read = 1'b0;
    logic       if_write_ce = 1'b0, if_write = 1'b0;
    logic [7:0] if_din = 8'h00;
    logic [7:0] if_dout;
    logic [2:0] if_count;
`ifdef KERNEL_BC_FIFO_ERRFLAG_EN
    logic       if_overflow, if_underflow;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    kernel_bc_fifo_srl_cnt #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .if_empty_n      (if_empty_n),
        .if_read_ce      (if_read_ce),
        .if_read         (if_read),
        .if_dout         (if_dout),
        .if_full_n       (if_full_n),
        .if_write_ce     (if_write_ce),
        .if_write        (if_write),
        .if_din          (if_din),
        .if_count        (if_count),
        .if_almost_full  (if_almost_full),
        .if_almost_empty (if_almost_empty)
`ifdef KERNEL_BC_FIFO_ERRFLAG_EN
        ,
        .if_overflow     (if_overflow),
        .if_underflow    (if_underflow)
`endif
    );

    // One clock with the given request pattern; returns 1 time unit after the edge, inputs idle.
    task automatic step(input logic wr, input logic wce, input logic [7:0] d,
                        input logic rd, input logic rce);
        if_write = wr; if_write_ce = wce; if_din = d;
        if_read = rd;  if_read_ce = rce;
        @(posedge clk);
        #1;
        if_write = 1'b0; if_write_ce = 1'b0; if_read = 1'b0; if_read_ce = 1'b0;
    endtask

    // Short reset pulse between edges, leaves the bench 1 unit after an edge.
    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (if_count !== 3'd0 || if_empty_n !== 1'b0 || if_full_n !== 1'b1 ||
            if_almost_full !== 1'b0 || if_almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold: cnt=%0d en=%b fn=%b af=%b ae=%b want 0 0 1 0 1",
                     if_count, if_empty_n, if_full_n, if_almost_full, if_almost_empty);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        checks++;
        if (if_count !== 3'd2 || if_empty_n !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_fill: cnt=%0d en=%b want 2 1", if_count, if_empty_n);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (if_count !== 3'd0 || if_empty_n !== 1'b0 || if_full_n !== 1'b1 ||
            if_almost_full !== 1'b0 || if_almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_async: cnt=%0d en=%b fn=%b af=%b ae=%b want 0 0 1 0 1",
                     if_count, if_empty_n, if_full_n, if_almost_full, if_almost_empty);
        end
`ifdef KERNEL_BC_FIFO_ERRFLAG_EN
        checks++;
        if (if_overflow !== 1'b0 || if_underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_errflags: ovf=%b unf=%b want 0 0", if_overflow, if_underflow);
        end
`endif
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (if_count !== 3'd0 || if_empty_n !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: cnt=%0d en=%b want 0 0", if_count, if_empty_n);
        end
    endtask

    task automatic test_fill();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic       af_exp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       ae_exp [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic       fn_exp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, vals[i], 1'b0, 1'b0);
            checks++;
            if (if_count !== 3'(i + 1) || if_almost_full !== af_exp[i] ||
                if_almost_empty !== ae_exp[i] || if_full_n !== fn_exp[i] ||
                if_empty_n !== 1'b1 || if_dout !== 8'h11) begin
                failures++;
                $display("FAIL fill_%0d: cnt=%0d af=%b ae=%b fn=%b en=%b dout=%h want %0d %b %b %b 1 11",
                         i, if_count, if_almost_full, if_almost_empty, if_full_n, if_empty_n,
                         if_dout, i + 1, af_exp[i], ae_exp[i], fn_exp[i]);
            end
        end
    endtask

    task automatic test_full_rw_and_drain();
        logic [7:0] dexp [2] = '{8'h33, 8'h44};
        step(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
        checks++;
        if (if_count !== 3'd3 || if_full_n !== 1'b1 || if_dout !== 8'h22 || if_almost_full !== 1'b1) begin
            failures++;
            $display("FAIL full_rw: cnt=%0d fn=%b dout=%h af=%b want 3 1 22 1",
                     if_count, if_full_n, if_dout, if_almost_full);
        end
`ifdef KERNEL_BC_FIFO_ERRFLAG_EN
        checks++;
        if (if_overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set: ovf=%b want 1", if_overflow);
        end
`endif
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            checks++;
            if (if_count !== 3'(2 - i) || if_dout !== dexp[i] || if_almost_empty !== (i == 1)) begin
                failures++;
                $display("FAIL drain_%0d: cnt=%0d dout=%h ae=%b want %0d %h %b",
                         i, if_count, if_dout, if_almost_empty, 2 - i, dexp[i], (i == 1));
            end
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checks++;
        if (if_count !== 3'd0 || if_empty_n !== 1'b0 || if_almost_empty !== 1'b1 || if_almost_full !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: cnt=%0d en=%b ae=%b af=%b want 0 0 1 0",
                     if_count, if_empty_n, if_almost_empty, if_almost_full);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] dexp [3] = '{8'hA1, 8'hA2, 8'hA2};
        pulse_reset();
        step(1'b1, 1'b1, 8'hA0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0);
        checks++;
        if (if_count !== 3'd2 || if_dout !== 8'hA0) begin
            failures++;
            $display("FAIL b2b_start: cnt=%0d dout=%h want 2 a0", if_count, if_dout);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'hA2, 1'b1, 1'b1);
            checks++;
            if (if_count !== 3'd2 || if_dout !== dexp[i]) begin
                failures++;
                $display("FAIL b2b_%0d: cnt=%0d dout=%h want 2 %h", i, if_count, if_dout, dexp[i]);
            end
        end
    endtask

    task automatic test_empty_rw();
        pulse_reset();
        step(1'b1, 1'b1, 8'h7E, 1'b1, 1'b1);
        checks++;
        if (if_empty_n !== 1'b1 || if_dout !== 8'h7E || if_count !== 3'd1) begin
            failures++;
            $display("FAIL empty_rw: en=%b dout=%h cnt=%0d want 1 7e 1", if_empty_n, if_dout, if_count);
        end
`ifdef KERNEL_BC_FIFO_ERRFLAG_EN
        checks++;
        if (if_underflow !== 1'b1 || if_overflow !== 1'b0) begin
            failures++;
            $display("FAIL underflow_set: unf=%b ovf=%b want 1 0", if_underflow, if_overflow);
        end
`endif
    endtask

    task automatic test_ce_gating();
        pulse_reset();
        step(1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
            checks++;
            if (if_count !== 3'd2 || if_dout !== 8'h01) begin
                failures++;
                $display("FAIL wce_gate_%0d: cnt=%0d dout=%h want 2 01", i, if_count, if_dout);
            end
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (if_count !== 3'd2 || if_dout !== 8'h01) begin
            failures++;
            $display("FAIL rce_gate: cnt=%0d dout=%h want 2 01", if_count, if_dout);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checks++;
        if (if_count !== 3'd1 || if_dout !== 8'h02) begin
            failures++;
            $display("FAIL gate_pop: cnt=%0d dout=%h want 1 02", if_count, if_dout);
        end
`ifdef KERNEL_BC_FIFO_ERRFLAG_EN
        checks++;
        if (if_overflow !== 1'b0 || if_underflow !== 1'b0) begin
            failures++;
            $display("FAIL gate_errflags: ovf=%b unf=%b want 0 0", if_overflow, if_underflow);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_rw_and_drain();
        test_back_to_back();
        test_empty_rw();
        test_ce_gating();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
